// File: rtl/cpu_run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_pkg
// Description : Shared run-state and command-op encodings for cpu_run_controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_run_pkg;

    typedef logic [1:0] run_state_t;
    typedef logic [1:0] cmd_op_t;

    localparam run_state_t c_RS_HALTED = 2'b00;
    localparam run_state_t c_RS_RUN    = 2'b01;
    localparam run_state_t c_RS_STEP   = 2'b10;

    localparam cmd_op_t c_OP_NOP  = 2'b00;
    localparam cmd_op_t c_OP_RUN  = 2'b01;
    localparam cmd_op_t c_OP_STEP = 2'b10;
    localparam cmd_op_t c_OP_HALT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_controller
// Description : Run/halt/single-step sequencer gating CPU commit via cpu_en.
//               Optional PC breakpoint enabled by defining CPU_RUN_BKPT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int STEP_W = 16,
    parameter int RET_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] step_count,
    input  logic [PC_W-1:0]   pc,
`ifdef CPU_RUN_BKPT_EN
    input  logic              bkpt_valid,
    input  logic [PC_W-1:0]   bkpt_addr,
    output logic              bkpt_hit,
`endif
    output logic              cpu_en,
    output logic              halted,
    output logic [1:0]        run_state,
    output logic              cmd_err,
    output logic [RET_W-1:0]  retired_cnt
);

    run_state_t        r_state;
    logic [STEP_W-1:0] r_remaining;
    logic [RET_W-1:0]  r_retired_cnt;
    logic              r_cmd_err;
    logic              w_accept;
    logic              w_active;
    logic              w_bkpt_match;
    logic              w_drop;

    assign w_accept = cmd_valid & cmd_ready;
    assign w_active = (r_state != c_RS_HALTED);
    assign w_drop   = w_accept & w_active & ((cmd_op == c_OP_RUN) | (cmd_op == c_OP_STEP));

`ifdef CPU_RUN_BKPT_EN
    logic r_skip;
    logic r_bkpt_hit;

    // skip lets a resume from the breakpoint PC execute it once instead of re-hitting
    assign w_bkpt_match = bkpt_valid & (pc == bkpt_addr) & w_active & ~r_skip;
    assign bkpt_hit     = r_bkpt_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip     <= 1'b0;
            r_bkpt_hit <= 1'b0;
        end else begin
            r_bkpt_hit <= w_bkpt_match;
            if (!w_active && w_accept && ((cmd_op == c_OP_RUN) || (cmd_op == c_OP_STEP)))
                r_skip <= 1'b1;
            else if (cpu_en)
                r_skip <= 1'b0;
        end
    end
`else
    logic w_pc_unused;

    assign w_bkpt_match = 1'b0;
    assign w_pc_unused  = ^pc;
`endif

    assign cmd_ready   = 1'b1;
    assign cpu_en      = w_active & ~w_bkpt_match;
    assign halted      = (r_state == c_RS_HALTED);
    assign run_state   = r_state;
    assign cmd_err     = r_cmd_err;
    assign retired_cnt = r_retired_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_RS_HALTED;
            r_remaining   <= '0;
            r_retired_cnt <= '0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_cmd_err <= w_drop;
            if (cpu_en)
                r_retired_cnt <= r_retired_cnt + RET_W'(1);

            case (r_state)
                c_RS_HALTED: begin
                    if (w_accept) begin
                        case (cmd_op)
                            c_OP_RUN:  r_state <= c_RS_RUN;
                            c_OP_STEP: begin
                                r_state     <= c_RS_STEP;
                                r_remaining <= (step_count == '0) ? STEP_W'(1) : step_count;
                            end
                            c_OP_NOP:  r_state <= c_RS_HALTED;
                            default:   r_state <= c_RS_HALTED;
                        endcase
                    end
                end
                c_RS_RUN: begin
                    if (w_bkpt_match || (w_accept && cmd_op == c_OP_HALT))
                        r_state <= c_RS_HALTED;
                end
                c_RS_STEP: begin
                    // a breakpoint leaves the remaining count unconsumed
                    if (w_bkpt_match) begin
                        r_state <= c_RS_HALTED;
                    end else begin
                        r_remaining <= r_remaining - STEP_W'(1);
                        if ((r_remaining == STEP_W'(1)) || (w_accept && cmd_op == c_OP_HALT))
                            r_state <= c_RS_HALTED;
                    end
                end
                default: r_state <= c_RS_HALTED;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_controller
// Description : Directed self-checking bench for cpu_run_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_controller;

    localparam int PC_W   = 32;
    localparam int STEP_W = 16;
    localparam int RET_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [STEP_W-1:0] step_count = '0;
    logic [PC_W-1:0]   pc = '0;
    logic              cpu_en;
    logic              halted;
    logic [1:0]        run_state;
    logic              cmd_err;
    logic [RET_W-1:0]  retired_cnt;
`ifdef CPU_RUN_BKPT_EN
    logic              bkpt_valid = 1'b0;
    logic [PC_W-1:0]   bkpt_addr = '0;
    logic              bkpt_hit;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cpu_run_controller #(.PC_W(PC_W), .STEP_W(STEP_W), .RET_W(RET_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .step_count  (step_count),
        .pc          (pc),
`ifdef CPU_RUN_BKPT_EN
        .bkpt_valid  (bkpt_valid),
        .bkpt_addr   (bkpt_addr),
        .bkpt_hit    (bkpt_hit),
`endif
        .cpu_en      (cpu_en),
        .halted      (halted),
        .run_state   (run_state),
        .cmd_err     (cmd_err),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; the fetch PC advances by 4 whenever the instruction committed
    task automatic tick();
        logic en;
        #2;
        en = cpu_en;
        @(posedge clk);
        #1;
        if (en) pc = pc + 32'd4;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [1:0] op, input logic [STEP_W-1:0] cnt);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        step_count = cnt;
        tick();
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
    endtask

    initial begin
        // 1: reset and idle
        ticks(3);
        rst = 1'b0;
        ticks(20);
        check_eq("idle_cpu_en", 32'(cpu_en), 32'd0);
        check_eq("idle_halted", 32'(halted), 32'd1);
        check_eq("idle_retired", retired_cnt, 32'd0);
        check_eq("idle_state", 32'(run_state), 32'd0);
        check_eq("idle_ready", 32'(cmd_ready), 32'd1);

        // 2: STEP 3 -> exactly 3 commits
        issue(2'b10, 16'd3);
        check_eq("step3_state", 32'(run_state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            check_eq("step3_en", 32'(cpu_en), 32'd1);
            tick();
        end
        check_eq("step3_en_after", 32'(cpu_en), 32'd0);
        check_eq("step3_halted", 32'(halted), 32'd1);
        check_eq("step3_retired", retired_cnt, 32'd3);

        // 3: STEP 0 -> one commit; RUN then HALT after 10 commits
        issue(2'b10, 16'd0);
        check_eq("step0_en", 32'(cpu_en), 32'd1);
        tick();
        check_eq("step0_halted", 32'(halted), 32'd1);
        check_eq("step0_retired", retired_cnt, 32'd4);
        issue(2'b01, 16'd0);
        check_eq("run_state", 32'(run_state), 32'd1);
        ticks(9);
        issue(2'b11, 16'd0);
        check_eq("run10_retired", retired_cnt, 32'd14);
        check_eq("run10_halted", 32'(halted), 32'd1);
        check_eq("run10_en", 32'(cpu_en), 32'd0);

        // 4: dropped STEP during RUN, HALT on final STEP cycle
        issue(2'b01, 16'd0);
        ticks(2);
        issue(2'b10, 16'd5);
        check_eq("drop_err", 32'(cmd_err), 32'd1);
        check_eq("drop_state", 32'(run_state), 32'd1);
        tick();
        check_eq("drop_err_clr", 32'(cmd_err), 32'd0);
        issue(2'b11, 16'd0);
        check_eq("drop_retired", retired_cnt, 32'd19);
        check_eq("drop_halted", 32'(halted), 32'd1);
        issue(2'b10, 16'd2);
        tick();
        issue(2'b11, 16'd0);
        check_eq("lasthalt_halted", 32'(halted), 32'd1);
        check_eq("lasthalt_err", 32'(cmd_err), 32'd0);
        check_eq("lasthalt_retired", retired_cnt, 32'd21);
        ticks(3);
        check_eq("lasthalt_hold", retired_cnt, 32'd21);

`ifdef CPU_RUN_BKPT_EN
        // 5: breakpoint at 0x10
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pc = 32'd0;
        bkpt_valid = 1'b1;
        bkpt_addr  = 32'h10;
        issue(2'b01, 16'd0);
        ticks(4);
        check_eq("bkpt_pc", pc, 32'h10);
        check_eq("bkpt_en", 32'(cpu_en), 32'd0);
        tick();
        check_eq("bkpt_hit", 32'(bkpt_hit), 32'd1);
        check_eq("bkpt_halted", 32'(halted), 32'd1);
        check_eq("bkpt_retired", retired_cnt, 32'd4);
        tick();
        check_eq("bkpt_hit_clr", 32'(bkpt_hit), 32'd0);
        issue(2'b01, 16'd0);
        check_eq("resume_en", 32'(cpu_en), 32'd1);
        tick();
        check_eq("resume_retired", retired_cnt, 32'd5);
        check_eq("resume_pc", pc, 32'h14);
        check_eq("resume_nohit", 32'(bkpt_hit), 32'd0);
        issue(2'b11, 16'd0);
        bkpt_valid = 1'b0;
`endif

        // 6: reset mid-RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(2'b01, 16'd0);
        ticks(5);
        check_eq("mid_retired", retired_cnt, 32'd5);
        rst = 1'b1;
        tick();
        check_eq("rst_en", 32'(cpu_en), 32'd0);
        check_eq("rst_retired", retired_cnt, 32'd0);
        check_eq("rst_state", 32'(run_state), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("rst_hold", retired_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
